// File: rtl/tl_pkg.sv
// Shared light codes, FSM state type and index-width helper
// for the traffic-light phase sequencer.
package tl_pkg;

  localparam logic [1:0] TL_RED    = 2'd0;
  localparam logic [1:0] TL_GREEN  = 2'd1;
  localparam logic [1:0] TL_YELLOW = 2'd2;

  typedef enum logic [1:0] {
    ALL_RED,
    GREEN,
    YELLOW
  } tl_state_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tl_rr_pick.sv
// Combinational round-robin picker: first pending approach
// after 'last', wrapping around and ending at 'last' itself.
module tl_rr_pick
  import tl_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int IW     = idx_w(NUM_CH)
) (
  input  logic [NUM_CH-1:0] pend,
  input  logic [IW-1:0]     last,
  output logic [IW-1:0]     pick,
  output logic              found
);

  int          idx;
  logic [IW-1:0] iw;

  always_comb begin
    pick  = last;
    found = 1'b0;
    idx   = 0;
    iw    = '0;
    for (int k = 1; k <= NUM_CH; k++) begin
      idx = (int'(last) + k) % NUM_CH;
      iw  = IW'(idx);
      if (!found && pend[iw]) begin
        found = 1'b1;
        pick  = iw;
      end
    end
  end

endmodule

// File: rtl/tl_phase_sequencer.sv
// N-approach round-robin traffic-light phase sequencer.
// Optional emergency preemption is built with TL_PREEMPT_EN.
module tl_phase_sequencer
  import tl_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = 7,
  parameter int GREEN_T     = 20,
  parameter int MIN_GREEN_T = 5,
  parameter int YELLOW_T    = 3,
  parameter int RED_T       = 2
) (
  input  logic                      clk,
  input  logic                      sys_reset,
  input  logic                      tick,
  input  logic [NUM_CH-1:0]         req,
`ifdef TL_PREEMPT_EN
  input  logic                      preempt,
  input  logic [$clog2(NUM_CH)-1:0] preempt_ch,
`endif
  output logic [2*NUM_CH-1:0]       light,
  output logic [$clog2(NUM_CH)-1:0] active_ch,
  output logic [CNT_W-1:0]          count,
  output logic                      phase_done
);

  localparam int IW = idx_w(NUM_CH);
  // gap-out allowed once count has fallen to this value
  localparam int GAP_MAX = GREEN_T - 1 - MIN_GREEN_T;

  tl_state_t           state, state_d;
  logic [NUM_CH-1:0]   pending, pending_d;
  logic [NUM_CH-1:0]   ch_oh;
  logic [IW-1:0]       active_d;
  logic [CNT_W-1:0]    count_d;
  logic                done_d;
  logic [2*NUM_CH-1:0] light_d;

  logic [IW-1:0] pick, grant_ch;
  logic          found, grant_ok;
  logic          hold, cut;
  logic          expire, gap;

  tl_rr_pick #(
    .NUM_CH (NUM_CH),
    .IW     (IW)
  ) u_pick (
    .pend  (pending),
    .last  (active_ch),
    .pick  (pick),
    .found (found)
  );

`ifdef TL_PREEMPT_EN
  assign hold     = preempt && (active_ch == preempt_ch);
  assign cut      = preempt && (active_ch != preempt_ch);
  assign grant_ok = preempt || found;
  assign grant_ch = preempt ? preempt_ch : pick;
`else
  assign hold     = 1'b0;
  assign cut      = 1'b0;
  assign grant_ok = found;
  assign grant_ch = pick;
`endif

  assign ch_oh  = NUM_CH'(1) << active_ch;
  assign expire = (count == '0);
  assign gap    = !req[active_ch]
               && |(pending & ~ch_oh)
               && (int'(count) <= GAP_MAX);

  always_ff @(posedge clk or posedge sys_reset) begin
    if (sys_reset) begin
      state      <= ALL_RED;
      count      <= CNT_W'(RED_T - 1);
      active_ch  <= IW'(NUM_CH - 1);
      pending    <= '0;
      light      <= '0;
      phase_done <= 1'b0;
    end else begin
      state      <= state_d;
      count      <= count_d;
      active_ch  <= active_d;
      pending    <= pending_d;
      light      <= light_d;
      phase_done <= done_d;
    end
  end

  always_comb begin
    state_d   = state;
    active_d  = active_ch;
    count_d   = count;
    done_d    = 1'b0;
    pending_d = pending
              | (req & ~((state == GREEN) ? ch_oh : '0));
    if (tick) begin
      unique case (state)
        ALL_RED: begin
          if (!expire) begin
            count_d = count - CNT_W'(1);
          end else if (grant_ok) begin
            state_d             = GREEN;
            active_d            = grant_ch;
            count_d             = CNT_W'(GREEN_T - 1);
            done_d              = 1'b1;
            pending_d[grant_ch] = 1'b0;
          end else begin
            count_d = CNT_W'(RED_T - 1);
          end
        end
        GREEN: begin
          if (hold) begin
            count_d = count;
          end else if (expire || gap || cut) begin
            state_d = YELLOW;
            count_d = CNT_W'(YELLOW_T - 1);
            done_d  = 1'b1;
          end else begin
            count_d = count - CNT_W'(1);
          end
        end
        YELLOW: begin
          if (expire) begin
            state_d = ALL_RED;
            count_d = CNT_W'(RED_T - 1);
            done_d  = 1'b1;
          end else begin
            count_d = count - CNT_W'(1);
          end
        end
        default: state_d = ALL_RED;
      endcase
    end
  end

  always_comb begin
    light_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (IW'(i) == active_d) begin
        unique case (state_d)
          GREEN:   light_d[2*i +: 2] = TL_GREEN;
          YELLOW:  light_d[2*i +: 2] = TL_YELLOW;
          default: light_d[2*i +: 2] = TL_RED;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tl_phase_sequencer.sv
// Bench for tl_phase_sequencer: directed scenarios then random
// req/tick traffic, all tracked by a phase-level reference model.
module tb_tl_phase_sequencer;

  localparam int N  = 4;
  localparam int CW = 7;
  localparam int GT = 8;
  localparam int MG = 3;
  localparam int YT = 3;
  localparam int RT = 2;

  logic           clk = 1'b0;
  logic           sys_reset;
  logic           tick;
  logic [N-1:0]   req;
  logic [2*N-1:0] light;
  logic [1:0]     active_ch;
  logic [CW-1:0]  count;
  logic           phase_done;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  // model: phase 0=all red, 1=green, 2=yellow; rem = ticks left
  int m_phase, m_rem, m_ch;
  bit m_pend [N];
  bit m_done;

  always #5 clk = ~clk;

  tl_phase_sequencer #(
    .NUM_CH      (N),
    .CNT_W       (CW),
    .GREEN_T     (GT),
    .MIN_GREEN_T (MG),
    .YELLOW_T    (YT),
    .RED_T       (RT)
  ) dut (
    .clk        (clk),
    .sys_reset  (sys_reset),
    .tick       (tick),
    .req        (req),
    .light      (light),
    .active_ch  (active_ch),
    .count      (count),
    .phase_done (phase_done)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_update();
    bit np [N];
    bit found, others, gapo;
    int nc, c;
    m_done = 1'b0;
    if (sys_reset) begin
      m_phase = 0;
      m_rem   = RT;
      m_ch    = N - 1;
      foreach (m_pend[i]) m_pend[i] = 1'b0;
      return;
    end
    np = m_pend;
    for (int i = 0; i < N; i++)
      if (req[i] && !(m_phase == 1 && m_ch == i)) np[i] = 1'b1;
    if (tick) begin
      case (m_phase)
        0: begin
          if (m_rem > 1) m_rem--;
          else begin
            found = 1'b0;
            nc = 0;
            for (int k = 1; k <= N; k++) begin
              c = (m_ch + k) % N;
              if (!found && m_pend[c]) begin
                found = 1'b1;
                nc = c;
              end
            end
            if (found) begin
              m_phase = 1;
              m_ch    = nc;
              m_rem   = GT;
              m_done  = 1'b1;
              np[nc]  = 1'b0;
            end else m_rem = RT;
          end
        end
        1: begin
          others = 1'b0;
          for (int i = 0; i < N; i++)
            if (i != m_ch && m_pend[i]) others = 1'b1;
          gapo = !req[m_ch] && others && ((GT - m_rem) >= MG);
          if (m_rem == 1 || gapo) begin
            m_phase = 2;
            m_rem   = YT;
            m_done  = 1'b1;
          end else m_rem--;
        end
        default: begin
          if (m_rem == 1) begin
            m_phase = 0;
            m_rem   = RT;
            m_done  = 1'b1;
          end else m_rem--;
        end
      endcase
    end
    m_pend = np;
  endtask

  task automatic compare();
    logic [2*N-1:0] e;
    e = '0;
    if (m_phase != 0)
      e[2*m_ch +: 2] = (m_phase == 1) ? 2'd1 : 2'd2;
    chk("light", light, e);
    chk("count", count, m_rem - 1);
    chk("active_ch", active_ch, m_ch);
    chk("phase_done", phase_done, m_done);
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    compare();
  endtask

  initial begin
    int pulses, greens, k;
    int order [$];

    sys_reset = 1'b1;
    tick      = 1'b1;
    req       = '0;
    step();
    step();
    chk("rst_light", light, 0);
    chk("rst_count", count, 1);
    chk("rst_active", active_ch, 3);
    chk("rst_done", phase_done, 0);
    sys_reset = 1'b0;

    pulses = 0;
    repeat (20) begin
      step();
      pulses += int'(phase_done);
    end
    chk("idle_pulses", pulses, 0);

    req = 4'b0100;
    step();
    req = '0;
    pulses = 0;
    greens = 0;
    repeat (16) begin
      step();
      pulses += int'(phase_done);
      if (light[5:4] == 2'd1) greens++;
    end
    chk("single_pulses", pulses, 3);
    chk("single_green_len", greens, 8);

    sys_reset = 1'b1;
    step();
    sys_reset = 1'b0;
    req = 4'b1111;
    k = 0;
    while (order.size() < 5 && k < 200) begin
      step();
      k++;
      if (phase_done && light[2*active_ch +: 2] == 2'd1)
        order.push_back(int'(active_ch));
    end
    chk("rr_grants", order.size(), 5);
    for (int i = 0; i < order.size(); i++)
      chk($sformatf("rr_order_%0d", i), order[i], i % N);

    sys_reset = 1'b1;
    step();
    sys_reset = 1'b0;
    req = 4'b0010;
    k = 0;
    while (light[3:2] != 2'd1 && k < 50) begin
      step();
      k++;
    end
    chk("gap_wait_green1", light[3:2], 1);
    greens = 1;
    step();
    if (light[3:2] == 2'd1) greens++;
    req = 4'b1000;
    repeat (10) begin
      step();
      if (light[3:2] == 2'd1) greens++;
    end
    chk("gap_green_len", greens, 4);
    k = 0;
    while (light[7:6] != 2'd1 && k < 50) begin
      step();
      k++;
    end
    chk("gap_next_grant", active_ch, 3);
    req = '0;

    k = 0;
    while (light[7:6] != 2'd2 && k < 50) begin
      step();
      k++;
    end
    chk("yellow_reached", light[7:6], 2);
    step();
    sys_reset = 1'b1;
    #1;
    chk("async_rst_light", light, 0);
    step();
    chk("yel_rst_light", light, 0);
    chk("yel_rst_count", count, 1);
    chk("yel_rst_active", active_ch, 3);
    sys_reset = 1'b0;

    tick = 1'b0;
    req  = 4'b0001;
    step();
    req  = '0;
    repeat (4) step();
    tick = 1'b1;
    repeat (6) step();

    repeat (500) begin
      req       = N'($urandom & $urandom);
      tick      = ($urandom_range(0, 3) != 0);
      sys_reset = ($urandom_range(0, 199) == 0);
      step();
    end
    sys_reset = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
